// File: rtl/mul_unit_pkg.sv
// Shared definitions for the multi-cycle RV32M multiplier: mulctl
// encodings (also used by the EX controller) and the MU state encoding.
package mul_unit_pkg;

  localparam int MU_WIDTH = 32;

  // mulctl = func3[1:0]
  localparam logic [1:0] MUL_LO  = 2'b00;  // MUL    : low half, signed x signed
  localparam logic [1:0] MUL_HSS = 2'b01;  // MULH   : high half, signed x signed
  localparam logic [1:0] MUL_HSU = 2'b10;  // MULHSU : high half, signed x unsigned
  localparam logic [1:0] MUL_HUU = 2'b11;  // MULHU  : high half, unsigned x unsigned

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mu_state_e;

  // rs1 is treated as signed for every op except MULHU
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op != MUL_HUU);
  endfunction

  // rs2 is treated as signed only for MUL and MULH
  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_LO) || (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Request/response bundle between the EX controller (master) and the
// multiplier (slave).
interface mul_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             mulstart;
  logic [1:0]       mulctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output mulstart, mulctl, a, b,
    input  result, busy, done
  );

  modport slave (
    input  mulstart, mulctl, a, b,
    output result, busy, done
  );

endinterface

// File: rtl/mul_unit.sv
// Multi-cycle RV32M multiplier. Operands are reduced to magnitudes, multiplied
// by radix-2 shift-add over WIDTH cycles, then the sign is reapplied and the
// requested product half is registered. Latency is fixed: done is high
// WIDTH+2 cycles after the accepting edge.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mul_unit_if.slave  mu
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mu_state_e          state_r;
  mu_state_e          next_state_s;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic [1:0]         op_r;
  logic               neg_r;
  logic [WIDTH-1:0]   result_r;
  logic               busy_r;
  logic               done_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operand magnitudes (unsigned, so the most negative value maps cleanly)
  // and the signed product reconstructed from the unsigned accumulator.
  always_comb begin
    a_neg_s = op_a_signed(mu.mulctl) & mu.a[WIDTH-1];
    b_neg_s = op_b_signed(mu.mulctl) & mu.b[WIDTH-1];
    if (a_neg_s) begin
      a_abs_s = ~mu.a + WIDTH'(1);
    end else begin
      a_abs_s = mu.a;
    end
    if (b_neg_s) begin
      b_abs_s = ~mu.b + WIDTH'(1);
    end else begin
      b_abs_s = mu.b;
    end
    if (neg_r) begin
      prod_s = ~acc_r + (2*WIDTH)'(1);
    end else begin
      prod_s = acc_r;
    end
  end

  // Next-state logic: fixed IDLE -> CALC(xWIDTH) -> SIGN -> DONE sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mu.mulstart) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = SIGN;
        end else begin
          next_state_s = CALC;
        end
      end
      SIGN:    next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: capture operands on start, one shift-add step per CALC cycle,
  // sign fix-up and half selection in SIGN.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      op_r     <= 2'b00;
      neg_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (mu.mulstart) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a_abs_s};
            mplier_r <= b_abs_s;
            cnt_r    <= {CW{1'b0}};
            op_r     <= mu.mulctl;
            neg_r    <= a_neg_s ^ b_neg_s;
          end
        end
        CALC: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
        end
        SIGN: begin
          if (op_r == MUL_LO) begin
            result_r <= prod_s[WIDTH-1:0];
          end else begin
            result_r <= prod_s[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered status: busy tracks any non-IDLE state, done marks DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
    end
  end

  assign mu.result = result_r;
  assign mu.busy   = busy_r;
  assign mu.done   = done_r;

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit. Cycle numbering: the start is
// accepted at edge 0 and cycle k is the period following edge k-1; outputs
// are sampled 1 time unit after each rising edge.
module tb_mul_unit;

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;

  mul_unit_if #(.WIDTH(32)) mu_if ();

  mul_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .mu  (mu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and watch cycles 1..45; reports result at done, cycle of the
  // last done, number of done pulses and number of cycles where busy was wrong.
  task automatic do_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] res, output int dcyc, output int nd, output int bbad);
    res  = 32'hxxxx_xxxx;
    dcyc = -1;
    nd   = 0;
    bbad = 0;
    @(posedge clk); #1;
    mu_if.mulstart = 1'b1;
    mu_if.mulctl   = op;
    mu_if.a        = av;
    mu_if.b        = bv;
    @(posedge clk); #1;
    mu_if.mulstart = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (mu_if.busy !== ((cyc <= 34) ? 1'b1 : 1'b0)) bbad++;
      if (mu_if.done === 1'b1) begin
        nd++;
        dcyc = cyc;
        res  = mu_if.result;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mu_if.mulstart = 1'b0;
    mu_if.mulctl   = 2'b00;
    mu_if.a        = 32'h0;
    mu_if.b        = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks_total++;
    if (mu_if.result !== 32'h0) $display("FAIL reset_result got=%h exp=%h", mu_if.result, 32'h0);
    else checks_passed++;
    checks_total++;
    if (mu_if.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", mu_if.busy);
    else checks_passed++;
    checks_total++;
    if (mu_if.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", mu_if.done);
    else checks_passed++;
  endtask

  task automatic test_mul_basic();
    logic [31:0] r;
    int dc, nd, bb;
    do_op(2'b00, 32'd7, 32'd6, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'h0000_002A) $display("FAIL mul_7x6 got=%h exp=%h", r, 32'h0000_002A);
    else checks_passed++;
    checks_total++;
    if (dc !== 34) $display("FAIL mul_done_cycle got=%0d exp=34", dc);
    else checks_passed++;
    checks_total++;
    if (nd !== 1) $display("FAIL mul_done_count got=%0d exp=1", nd);
    else checks_passed++;
    checks_total++;
    if (bb !== 0) $display("FAIL mul_busy_window bad_cycles=%0d exp=0", bb);
    else checks_passed++;
    checks_total++;
    if (mu_if.result !== 32'h0000_002A) $display("FAIL mul_result_held got=%h exp=%h", mu_if.result, 32'h0000_002A);
    else checks_passed++;
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int dc, nd, bb;
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'hFFFF_FFF1) $display("FAIL mul_neg3x5 got=%h exp=%h", r, 32'hFFFF_FFF1);
    else checks_passed++;
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'hFFFF_FFFF) $display("FAIL mulh_neg3x5 got=%h exp=%h", r, 32'hFFFF_FFFF);
    else checks_passed++;
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'h4000_0000) $display("FAIL mulh_minxmin got=%h exp=%h", r, 32'h4000_0000);
    else checks_passed++;
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'h0000_0000) $display("FAIL mul_minxmin got=%h exp=%h", r, 32'h0000_0000);
    else checks_passed++;
  endtask

  task automatic test_mixed_unsigned();
    logic [31:0] r;
    int dc, nd, bb;
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu_ones got=%h exp=%h", r, 32'hFFFF_FFFF);
    else checks_passed++;
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu_ones got=%h exp=%h", r, 32'hFFFF_FFFE);
    else checks_passed++;
    checks_total++;
    if (dc !== 34) $display("FAIL mulhu_done_cycle got=%0d exp=34", dc);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int d1, d2, nd;
    r1 = 32'hxxxx_xxxx;
    r2 = 32'hxxxx_xxxx;
    d1 = -1;
    d2 = -1;
    nd = 0;
    @(posedge clk); #1;
    mu_if.mulstart = 1'b1;
    mu_if.mulctl   = 2'b00;
    mu_if.a        = 32'd3;
    mu_if.b        = 32'd4;
    @(posedge clk); #1;
    mu_if.mulstart = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (mu_if.done === 1'b1) begin
        nd++;
        if (nd == 1) begin
          d1 = cyc;
          r1 = mu_if.result;
        end else begin
          d2 = cyc;
          r2 = mu_if.result;
        end
      end
      if (cyc == 5) begin
        mu_if.mulstart = 1'b1;
        mu_if.a = 32'd9;
        mu_if.b = 32'd9;
      end else if (cyc == 35) begin
        mu_if.mulstart = 1'b1;
        mu_if.mulctl   = 2'b00;
        mu_if.a = 32'd5;
        mu_if.b = 32'd5;
      end else begin
        mu_if.mulstart = 1'b0;
        mu_if.a = 32'h1111_1111 * cyc;
        mu_if.b = 32'h0101_0101 + cyc;
        mu_if.mulctl = 2'(cyc);
      end
      @(posedge clk); #1;
    end
    checks_total++;
    if (d1 !== 34) $display("FAIL restart_ignored_done_cycle got=%0d exp=34", d1);
    else checks_passed++;
    checks_total++;
    if (r1 !== 32'h0000_000C) $display("FAIL restart_ignored_result got=%h exp=%h", r1, 32'h0000_000C);
    else checks_passed++;
    checks_total++;
    if (nd !== 2) $display("FAIL b2b_done_count got=%0d exp=2", nd);
    else checks_passed++;
    checks_total++;
    if (d2 !== 69) $display("FAIL b2b_done_cycle got=%0d exp=69", d2);
    else checks_passed++;
    checks_total++;
    if (r2 !== 32'h0000_0019) $display("FAIL b2b_result got=%h exp=%h", r2, 32'h0000_0019);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    int dc, nd, bb, late_done;
    late_done = 0;
    @(posedge clk); #1;
    mu_if.mulstart = 1'b1;
    mu_if.mulctl   = 2'b00;
    mu_if.a        = 32'd100;
    mu_if.b        = 32'd3;
    @(posedge clk); #1;
    mu_if.mulstart = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 10) begin
        rst = 1'b1;
      end else if (cyc == 11) begin
        rst = 1'b0;
        checks_total++;
        if (mu_if.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", mu_if.busy);
        else checks_passed++;
        checks_total++;
        if (mu_if.done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", mu_if.done);
        else checks_passed++;
        checks_total++;
        if (mu_if.result !== 32'h0) $display("FAIL midrst_result got=%h exp=%h", mu_if.result, 32'h0);
        else checks_passed++;
      end else if (mu_if.done === 1'b1) begin
        late_done++;
      end
      @(posedge clk); #1;
    end
    checks_total++;
    if (late_done !== 0) $display("FAIL midrst_no_done got=%0d exp=0", late_done);
    else checks_passed++;
    do_op(2'b00, 32'd2, 32'd2, r, dc, nd, bb);
    checks_total++;
    if (r !== 32'h0000_0004) $display("FAIL after_rst_2x2 got=%h exp=%h", r, 32'h0000_0004);
    else checks_passed++;
    checks_total++;
    if (nd !== 1) $display("FAIL after_rst_done_count got=%0d exp=1", nd);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_reset();
    test_mul_basic();
    test_signed();
    test_mixed_unsigned();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
